// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - loadable BCD up/down counter with wrap or saturate at the limits
module bcd_updown_counter #(
  parameter int DIGITS = 3,
  parameter bit WRAP   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  input  logic                en,
  input  logic                up,
  output logic [4*DIGITS-1:0] count,
  output logic                V,
  output logic                err,
  output logic                tc
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]      inc_val;
  logic [W-1:0]      dec_val;
  logic [DIGITS:0]   carry;
  logic [DIGITS:0]   borrow;
  logic [DIGITS-1:0] nine_d;
  logic [DIGITS-1:0] zero_d;
  logic [DIGITS-1:0] bad_d;
  logic              all_nines;
  logic              all_zero;
  logic              din_ok;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  // carry[k]/borrow[k] mean every lower digit rolls over, so digit k must step
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [3:0] d;
    logic [3:0] l;

    assign d            = count[4*k +: 4];
    assign l            = din[4*k +: 4];
    assign nine_d[k]    = (d == 4'd9);
    assign zero_d[k]    = (d == 4'd0);
    assign bad_d[k]     = (l > 4'd9);
    assign carry[k+1]   = carry[k] & nine_d[k];
    assign borrow[k+1]  = borrow[k] & zero_d[k];
    assign inc_val[4*k +: 4] = !carry[k]  ? d : (nine_d[k] ? 4'd0 : d + 4'd1);
    assign dec_val[4*k +: 4] = !borrow[k] ? d : (zero_d[k] ? 4'd9 : d - 4'd1);
  end

  assign all_nines = carry[DIGITS];
  assign all_zero  = borrow[DIGITS];
  assign din_ok    = ~|bad_d;
  assign tc        = up ? all_nines : all_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      V     <= 1'b0;
      err   <= 1'b0;
    end else begin
      V   <= 1'b0;
      err <= 1'b0;
      if (load) begin
        if (din_ok) begin
          count <= din;
        end else begin
          err <= 1'b1;
        end
      end else if (en) begin
        // the digit chain already yields the wrapped value at the limits
        if (up) begin
          V <= all_nines;
          if (!(all_nines && !WRAP)) begin
            count <= inc_val;
          end
        end else begin
          V <= all_zero;
          if (!(all_zero && !WRAP)) begin
            count <= dec_val;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - checks four counter configurations against an integer reference model
module tb_bcd_updown_counter;

  logic             clk = 1'b0;
  logic [3:0]       rst_a;
  logic [3:0]       load_a;
  logic [3:0]       en_a;
  logic [3:0]       up_a;
  logic [3:0][15:0] din_p;
  logic [11:0]      c0;
  logic [11:0]      c1;
  logic [3:0]       c2;
  logic [15:0]      c3;
  logic [3:0]       v_o;
  logic [3:0]       e_o;
  logic [3:0]       t_o;

  int  n_assert = 0;
  int  n_fail   = 0;
  int  mval[4];
  bit  exp_v[4];
  bit  exp_e[4];
  int  ndig[4] = '{3, 3, 1, 4};
  bit  wr[4]   = '{1'b1, 1'b0, 1'b1, 1'b1};
  int  seen[10000];

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(3), .WRAP(1'b1)) u_w3 (
    .clk(clk), .rst(rst_a[0]), .load(load_a[0]), .din(din_p[0][11:0]), .en(en_a[0]),
    .up(up_a[0]), .count(c0), .V(v_o[0]), .err(e_o[0]), .tc(t_o[0]));
  bcd_updown_counter #(.DIGITS(3), .WRAP(1'b0)) u_s3 (
    .clk(clk), .rst(rst_a[1]), .load(load_a[1]), .din(din_p[1][11:0]), .en(en_a[1]),
    .up(up_a[1]), .count(c1), .V(v_o[1]), .err(e_o[1]), .tc(t_o[1]));
  bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) u_w1 (
    .clk(clk), .rst(rst_a[2]), .load(load_a[2]), .din(din_p[2][3:0]), .en(en_a[2]),
    .up(up_a[2]), .count(c2), .V(v_o[2]), .err(e_o[2]), .tc(t_o[2]));
  bcd_updown_counter #(.DIGITS(4), .WRAP(1'b1)) u_w4 (
    .clk(clk), .rst(rst_a[3]), .load(load_a[3]), .din(din_p[3]), .en(en_a[3]),
    .up(up_a[3]), .count(c3), .V(v_o[3]), .err(e_o[3]), .tc(t_o[3]));

  function automatic int pow10(int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic bit bcd_ok(logic [15:0] b, int n);
    for (int k = 0; k < n; k++) if (((b >> (4 * k)) & 16'hF) > 16'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(logic [15:0] b, int n);
    int r = 0;
    for (int k = n - 1; k >= 0; k--) r = r * 10 + int'((b >> (4 * k)) & 16'hF);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(int v, int n);
    logic [15:0] r = '0;
    for (int k = 0; k < n; k++) begin
      r = r | (16'(v % 10) << (4 * k));
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] cnt(int i);
    case (i)
      0:       return {4'h0, c0};
      1:       return {4'h0, c1};
      2:       return {12'h0, c2};
      default: return c3;
    endcase
  endfunction

  task automatic set(int i, bit r, bit l, logic [15:0] d, bit e, bit u);
    rst_a[i]  = r;
    load_a[i] = l;
    din_p[i]  = d;
    en_a[i]   = e;
    up_a[i]   = u;
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int mod = pow10(ndig[i]);
      logic [15:0] b = din_p[i] & 16'((32'd1 << (4 * ndig[i])) - 1);
      exp_v[i] = 1'b0;
      exp_e[i] = 1'b0;
      if (rst_a[i]) mval[i] = 0;
      else if (load_a[i]) begin
        if (bcd_ok(b, ndig[i])) mval[i] = bcd2int(b, ndig[i]);
        else exp_e[i] = 1'b1;
      end else if (en_a[i]) begin
        if (up_a[i]) begin
          if (mval[i] == mod - 1) begin
            exp_v[i] = 1'b1;
            if (wr[i]) mval[i] = 0;
          end else mval[i] = mval[i] + 1;
        end else begin
          if (mval[i] == 0) begin
            exp_v[i] = 1'b1;
            if (wr[i]) mval[i] = mod - 1;
          end else mval[i] = mval[i] - 1;
        end
      end
    end
  endtask

  task automatic check(int i, string tag);
    int          mod = pow10(ndig[i]);
    logic [15:0] ec  = int2bcd(mval[i], ndig[i]);
    logic        et  = up_a[i] ? (mval[i] == mod - 1) : (mval[i] == 0);
    n_assert++;
    assert (cnt(i) === ec) else begin
      n_fail++;
      $error("FAIL %s.count[%0d] got %h expected %h", tag, i, cnt(i), ec);
    end
    n_assert++;
    assert (v_o[i] === exp_v[i]) else begin
      n_fail++;
      $error("FAIL %s.V[%0d] got %b expected %b", tag, i, v_o[i], exp_v[i]);
    end
    n_assert++;
    assert (e_o[i] === exp_e[i]) else begin
      n_fail++;
      $error("FAIL %s.err[%0d] got %b expected %b", tag, i, e_o[i], exp_e[i]);
    end
    n_assert++;
    assert (t_o[i] === et) else begin
      n_fail++;
      $error("FAIL %s.tc[%0d] got %b expected %b", tag, i, t_o[i], et);
    end
  endtask

  task automatic tick(string tag);
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) check(i, tag);
  endtask

  task automatic sweep(int i, bit dir);
    int mod   = pow10(ndig[i]);
    int vcnt  = 0;
    int once  = 0;
    for (int k = 0; k < mod; k++) seen[k] = 0;
    set(i, 0, 1, 16'h0, 0, dir);
    tick("sweep_load");
    set(i, 0, 0, 16'h0, 1, dir);
    for (int k = 0; k < mod; k++) begin
      int idx;
      tick("sweep");
      idx = bcd2int(cnt(i), ndig[i]);
      if (idx < mod) seen[idx]++;
      if (v_o[i]) vcnt++;
    end
    set(i, 0, 0, 16'h0, 0, dir);
    for (int k = 0; k < mod; k++) if (seen[k] == 1) once++;
    n_assert++;
    assert (once === mod) else begin
      n_fail++;
      $error("FAIL sweep_visit[%0d] dir=%0b got %0d expected %0d", i, dir, once, mod);
    end
    n_assert++;
    assert (vcnt === 1) else begin
      n_fail++;
      $error("FAIL sweep_v[%0d] dir=%0b got %0d expected 1", i, dir, vcnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mval[i] = 0;
      set(i, 1, 1, 16'h0155, 1, 1);
    end
    tick("reset");
    for (int i = 0; i < 4; i++) set(i, 0, 0, 16'h0, 0, 1);
    tick("idle");

    // carry and borrow chains, wrap mode
    set(0, 0, 1, 16'h099, 1, 1); tick("ld099");
    set(0, 0, 0, 16'h000, 1, 1); tick("carry");
    set(0, 0, 1, 16'h999, 1, 1); tick("ld999");
    set(0, 0, 0, 16'h000, 1, 1); tick("wrap_up");
    set(0, 0, 0, 16'h000, 0, 1); tick("v_clear");
    set(0, 0, 1, 16'h100, 1, 0); tick("ld100");
    set(0, 0, 0, 16'h000, 1, 0); tick("borrow");
    set(0, 0, 1, 16'h000, 1, 0); tick("ld000");
    set(0, 0, 0, 16'h000, 1, 0); tick("wrap_dn");
    // back-to-back V with direction changes
    set(0, 0, 0, 16'h000, 1, 1); tick("v_again_up");
    set(0, 0, 0, 16'h000, 1, 0); tick("v_again_dn");
    set(0, 0, 0, 16'h000, 0, 0); tick("v_drop");

    // saturation mode
    set(1, 0, 1, 16'h999, 0, 1); tick("sat_ld999");
    set(1, 0, 0, 16'h000, 1, 1);
    for (int k = 0; k < 3; k++) tick("sat_up");
    set(1, 0, 1, 16'h000, 0, 0); tick("sat_ld000");
    set(1, 0, 0, 16'h000, 1, 0);
    for (int k = 0; k < 2; k++) tick("sat_dn");
    set(1, 0, 0, 16'h000, 0, 0); tick("sat_idle");

    // rejected load, load priority, hold, reset priority
    set(0, 0, 1, 16'h042, 0, 1); tick("ld042");
    set(0, 0, 1, 16'h0A5, 1, 1); tick("bad_load");
    set(0, 0, 0, 16'h000, 0, 1); tick("err_clear");
    set(0, 0, 1, 16'h123, 1, 1); tick("ld_over_en");
    set(0, 0, 0, 16'h000, 0, 1);
    for (int k = 0; k < 5; k++) tick("hold");
    set(0, 1, 1, 16'h555, 1, 1); tick("rst_over_ld");
    set(0, 0, 1, 16'h456, 0, 1); tick("ld456");
    set(0, 0, 0, 16'h000, 1, 1); tick("to457");
    set(0, 1, 0, 16'h000, 1, 1); tick("rst_mid");
    set(0, 0, 0, 16'h000, 1, 1); tick("resume");

    // randomized traffic on all four counters
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) begin
        int          mod = pow10(ndig[i]);
        int          sel = $urandom_range(0, 9);
        logic [15:0] d;
        if (sel < 4) d = int2bcd($urandom_range(0, mod - 1), ndig[i]);
        else if (sel < 6) d = 16'($urandom);
        else if (sel < 8) d = int2bcd(mod - 1, ndig[i]);
        else d = 16'h0;
        set(i, $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, d,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      end
      tick("rand");
    end

    for (int i = 0; i < 4; i++) set(i, 0, 0, 16'h0, 0, 1);
    tick("pre_sweep");
    sweep(2, 1'b1);
    sweep(2, 1'b0);
    sweep(3, 1'b1);
    sweep(3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 3, giving the number of BCD digits (range 1..8).
REQ-002 SHALL have parameter WRAP, default 1: 1 = wrap modulo 10^DIGITS; 0 = saturate at the limits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port load  input  1  synchronous parallel-load request.
REQ-006 SHALL have port din  input  4*DIGITS  load value; digit k occupies bits [4k+3:4k], with digit 0 as the least significant.
REQ-007 SHALL have port en  input  1  count enable.
REQ-008 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 SHALL have port count  output  4*DIGITS  registered BCD count value.
REQ-010 SHALL have port V  output  1  registered one-cycle pulse on overflow or underflow.
REQ-011 SHALL have port err  output  1  registered one-cycle pulse on a rejected load.
REQ-012 SHALL have port tc  output  1  combinational terminal count: count is all 9s when up=1, or zero when up=0.

Function
REQ-013 SHALL resolve priority per edge as rst > load > en > hold.
REQ-014 SHALL, on load=1 with every din nibble <= 9, set count = din on that edge, with V=0 and err=0 in the next cycle.
REQ-015 SHALL, on load=1 with any din nibble > 9, leave count unchanged, set err=1 for exactly the next cycle, and drop the count request.
REQ-016 SHALL, on en=1, up=1 and load=0, increment count by 1 in decimal: a digit at 9 becomes 0 and carries into the next digit, and a digit below 9 increments with no further carry.
REQ-017 SHALL, on en=1, up=0 and load=0, decrement count by 1 in decimal: a digit at 0 becomes 9 and borrows from the next digit, and a digit above 0 decrements with no further borrow.
REQ-018 SHALL, on an increment from all 9s, go to all 0s when WRAP=1 and hold all 9s when WRAP=0, asserting V=1 for one cycle in both modes.
REQ-019 SHALL, on a decrement from zero, go to all 9s when WRAP=1 and hold zero when WRAP=0, asserting V=1 for one cycle in both modes.
REQ-020 SHALL, on en=0 and load=0, hold count, with V=0 and err=0 in the next cycle.
REQ-021 SHALL show the count result on the edge after en is sampled, a latency of 1 cycle with no additional pipeline stage.
REQ-022 SHALL deassert V and err on every cycle not covered by REQ-015, REQ-018 or REQ-019, so that no pulse is ever stretched across consecutive events unless each event recurs.
REQ-023 SHALL change tc immediately with up and count, with no registered delay.
REQ-024 SHALL, on consecutive V events (for example WRAP=1 with repeated decrements past zero), assert V on each qualifying cycle only.
REQ-025 SHALL never produce a nibble > 9 in count under any input sequence.
REQ-026 SHALL, on a direction change between consecutive enabled cycles, apply each cycle's own up value with no extra delay.

Reset
REQ-027 SHALL, with rst=1 at a rising edge, set count=0, V=0 and err=0, overriding load and en.
REQ-028 SHALL, when rst is asserted mid-count (for example count=0x457 with en=1), give count=0x000 on that edge and resume counting from 0x000 on the first edge after rst falls.
REQ-029 SHALL provide no asynchronous reset path and no reset-dependent output other than these three registers.

Verification (DIGITS=3 unless stated)
REQ-030 SHALL cover carry chain with WRAP=1: load 0x099, en=1, up=1, one edge -> count=0x100, V=0; load 0x999, one edge -> count=0x000, V=1 for one cycle.
REQ-031 SHALL cover borrow chain with WRAP=1: load 0x100, up=0, one edge -> count=0x099; load 0x000, one edge -> count=0x999, V=1.
REQ-032 SHALL cover saturation with WRAP=0: load 0x999, up=1, 3 edges -> count stays 0x999, V=1 each cycle; up=0 from 0x000 -> stays 0x000, V=1.
REQ-033 SHALL cover invalid load: count=0x042, load din=0x0A5 with en=1 -> count stays 0x042, err=1 for one cycle, no increment on that edge.
REQ-034 SHALL cover priority and hold: load=1 din=0x123 with en=1 -> count=0x123 (no increment); en=0 for 5 edges -> count stays 0x123; rst=1 with load=1 -> count=0x000.
REQ-035 SHALL cover the parameter sweep: DIGITS=1 and DIGITS=4, full up and down cycles through 10^DIGITS counts -> every value visited once and V exactly once per wrap.
